irq_sequencer: RTL

- Interrupt and reset arbiter for the hmc-6502 control FSM.
- Arbitrates between reset, NMI, IRQ and software BRK, and picks which one owns the next instruction boundary.
- At that boundary it makes the control unit substitute opcode 8'h00 for the fetched opcode, and it drives the vector select to the address unit.
- Sits between the external interrupt pins and control; consumes control's last_cycle and a sequence-done strobe.

---
 rtl/irq_sequencer_if.sv | 25 ++
 rtl/irq_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/irq_sequencer_if.sv
// Interrupt-pin / control-unit bundle for irq_sequencer: the master side drives
// the pins and control strobes, the slave side (the sequencer) returns vector controls.
interface irq_sequencer_if;
  logic       irq;
  logic       nmi;
  logic [7:0] p;
  logic       last_cycle;
  logic       brk_op;
  logic       seq_done;
  logic       force_int;
  logic [1:0] vector_sel;
  logic       push_b;
  logic       suppress_wr;
  logic       busy;

  modport master (
    output irq, nmi, p, last_cycle, brk_op, seq_done,
    input  force_int, vector_sel, push_b, suppress_wr, busy
  );

  modport slave (
    input  irq, nmi, p, last_cycle, brk_op, seq_done,
    output force_int, vector_sel, push_b, suppress_wr, busy
  );
endinterface

// File: rtl/irq_sequencer.sv
// Reset/NMI/IRQ/BRK arbiter for the hmc-6502 control FSM; picks the owner of the next
// instruction boundary. Define IRQ_SYNC_EN to pass irq/nmi through 2-flop synchronizers.
module irq_sequencer #(
  parameter int RESET_HOLD = 2
) (
  input logic            ph1,
  input logic            reset,
  irq_sequencer_if.slave bus
);

  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_RST_SVC  = 2'd1;
  localparam logic [1:0] ST_IDLE     = 2'd2;
  localparam logic [1:0] ST_SERVICE  = 2'd3;

  localparam logic [1:0] VEC_NONE = 2'b00;
  localparam logic [1:0] VEC_NMI  = 2'b01;
  localparam logic [1:0] VEC_RST  = 2'b10;
  localparam logic [1:0] VEC_IRQ  = 2'b11;

  logic [1:0] r_state;
  logic [3:0] r_hold;
  logic       r_nmi_q;
  logic       r_nmi_pend;
  logic       r_force_int;
  logic [1:0] r_vector_sel;
  logic       r_push_b;
  logic       r_suppress_wr;
  logic       r_busy;

  logic w_irq;
  logic w_nmi;
  logic w_nmi_edge;
  logic w_nmi_any;
  logic w_irq_ok;
  logic w_unused_p;

`ifdef IRQ_SYNC_EN
  logic r_irq_s1, r_irq_s2, r_nmi_s1, r_nmi_s2;

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_irq_s1 <= 1'b0;
      r_irq_s2 <= 1'b0;
      r_nmi_s1 <= 1'b0;
      r_nmi_s2 <= 1'b0;
    end else begin
      r_irq_s1 <= bus.irq;
      r_irq_s2 <= r_irq_s1;
      r_nmi_s1 <= bus.nmi;
      r_nmi_s2 <= r_nmi_s1;
    end
  end

  assign w_irq = r_irq_s2;
  assign w_nmi = r_nmi_s2;
`else
  assign w_irq = bus.irq;
  assign w_nmi = bus.nmi;
`endif

  // An NMI edge landing on the deciding edge counts as pending right away.
  assign w_nmi_edge = w_nmi & ~r_nmi_q;
  assign w_nmi_any  = r_nmi_pend | w_nmi_edge;
  assign w_irq_ok   = w_irq & ~bus.p[2];
  assign w_unused_p = ^{bus.p[7:3], bus.p[1:0]};

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state       <= ST_RST_HOLD;
      r_hold        <= 4'(RESET_HOLD);
      r_nmi_q       <= 1'b0;
      r_nmi_pend    <= 1'b0;
      r_force_int   <= 1'b0;
      r_vector_sel  <= VEC_RST;
      r_push_b      <= 1'b0;
      r_suppress_wr <= 1'b1;
      r_busy        <= 1'b1;
    end else begin
      r_nmi_q     <= w_nmi;
      r_force_int <= 1'b0;
      if (w_nmi_edge)
        r_nmi_pend <= 1'b1;

      case (r_state)
        ST_RST_HOLD: begin
          if (r_hold <= 4'd1) begin
            r_state     <= ST_RST_SVC;
            r_force_int <= 1'b1;
          end else begin
            r_hold <= r_hold - 4'd1;
          end
        end

        ST_RST_SVC: begin
          if (bus.seq_done) begin
            r_state       <= ST_IDLE;
            r_vector_sel  <= VEC_NONE;
            r_suppress_wr <= 1'b0;
            r_busy        <= 1'b0;
          end
        end

        ST_IDLE: begin
          if (bus.last_cycle && w_nmi_any) begin
            r_state      <= ST_SERVICE;
            r_force_int  <= 1'b1;
            r_vector_sel <= VEC_NMI;
            r_push_b     <= 1'b0;
            r_nmi_pend   <= 1'b0;
            r_busy       <= 1'b1;
          end else if (bus.last_cycle && w_irq_ok) begin
            r_state      <= ST_SERVICE;
            r_force_int  <= 1'b1;
            r_vector_sel <= VEC_IRQ;
            r_push_b     <= 1'b0;
            r_busy       <= 1'b1;
          end else if (bus.brk_op) begin
            // A BRK colliding with a pending NMI keeps B=1 but takes the NMI vector.
            r_state      <= ST_SERVICE;
            r_vector_sel <= w_nmi_any ? VEC_NMI : VEC_IRQ;
            r_push_b     <= 1'b1;
            r_nmi_pend   <= 1'b0;
            r_busy       <= 1'b1;
          end
        end

        default: begin
          if (bus.seq_done) begin
            r_state      <= ST_IDLE;
            r_vector_sel <= VEC_NONE;
            r_push_b     <= 1'b0;
            r_busy       <= 1'b0;
          end else if (w_nmi_any && r_vector_sel == VEC_IRQ) begin
            r_vector_sel <= VEC_NMI;
            r_nmi_pend   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.force_int   = r_force_int;
  assign bus.vector_sel  = r_vector_sel;
  assign bus.push_b      = r_push_b;
  assign bus.suppress_wr = r_suppress_wr;
  assign bus.busy        = r_busy;

endmodule
